// File: rtl/umem_pkg.sv
// Shared types and helpers for the unified-memory arbiter and its response pipeline.
package umem_pkg;

  localparam int MEM_WORDS_DEF = 2048;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } resp_t;

  // Word-aligned and inside the memory; anything else gets an error response.
  function automatic logic addr_legal(input logic [31:0] addr, input int mem_words);
    return (addr[1:0] == 2'b00) && (addr < 32'(4 * mem_words));
  endfunction

endpackage

// File: rtl/umem_resp_pipe.sv
// Fixed-latency shift register of response entries; a flush drops every fetch-owned entry,
// including the one currently presented at the head.
module umem_resp_pipe
  import umem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  resp_t i_push,
  input  logic  i_flush_if,
  output resp_t o_head
);

  resp_t r_stage [LATENCY];

  function automatic resp_t kill_if(input resp_t e, input logic flush);
    resp_t r;
    r = e;
    if (flush && (e.owner == OWN_IF)) r.valid = 1'b0;
    return r;
  endfunction

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_first
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_stage[0] <= '0;
        else       r_stage[0] <= i_push;
      end
    end else begin : g_rest
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_stage[g] <= '0;
        else       r_stage[g] <= kill_if(r_stage[g-1], i_flush_if);
      end
    end
  end

  assign o_head = kill_if(r_stage[LATENCY-1], i_flush_if);

endmodule

// File: rtl/umem_arbiter.sv
// Single-port arbiter between instruction fetch and load/store in front of the unified data_mem.
// LS has priority, but a bounded LS streak guarantees a waiting fetch eventually wins.
module umem_arbiter
  import umem_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MEM_WORDS     = MEM_WORDS_DEF,
  parameter int MEM_LATENCY   = 1,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [DATA_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_err,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [DATA_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_ls_err,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);

  logic [STREAK_W-1:0] r_streak;
  logic                w_if_legal;
  logic                w_ls_legal;
  logic                w_streak_full;
  logic                w_if_win;
  logic                w_if_gnt;
  logic                w_ls_gnt;
  logic                w_if_rsp;
  logic                w_ls_rsp;
  resp_t               w_push;
  resp_t               w_head;

  assign w_if_legal    = addr_legal(i_if_addr, MEM_WORDS);
  assign w_ls_legal    = addr_legal(i_ls_addr, MEM_WORDS);
  assign w_streak_full = (r_streak == STREAK_W'(MAX_LS_STREAK));

  // Fetch wins only when LS is idle or LS has used up its streak; a flush vetoes fetch.
  assign w_if_win = i_if_req & ~i_if_flush & (~i_ls_req | w_streak_full);
  assign w_if_gnt = ~i_rst & w_if_win;
  assign w_ls_gnt = ~i_rst & i_ls_req & ~w_if_win;

  assign o_if_gnt = w_if_gnt;
  assign o_ls_gnt = w_ls_gnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_streak <= '0;
    end else if (!i_if_req || w_if_gnt) begin
      r_streak <= '0;
    end else if (w_ls_gnt && !w_streak_full) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // Illegal accesses still occupy the port slot but never write; legal stores need no response.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    w_push      = '0;
    if (w_if_gnt) begin
      o_mem_addr = {i_if_addr[DATA_W-1:2], 2'b00};
      w_push     = '{valid: 1'b1, owner: OWN_IF, err: ~w_if_legal};
    end else if (w_ls_gnt) begin
      o_mem_addr  = {i_ls_addr[DATA_W-1:2], 2'b00};
      o_mem_wdata = i_ls_wdata;
      o_mem_we    = i_ls_we & w_ls_legal;
      if (!(i_ls_we && w_ls_legal)) begin
        w_push = '{valid: 1'b1, owner: OWN_LS, err: ~w_ls_legal};
      end
    end
  end

  umem_resp_pipe #(
    .LATENCY(MEM_LATENCY)
  ) u_resp_pipe (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (w_push),
    .i_flush_if(i_if_flush),
    .o_head    (w_head)
  );

  assign w_if_rsp = w_head.valid & (w_head.owner == OWN_IF);
  assign w_ls_rsp = w_head.valid & (w_head.owner == OWN_LS);

  assign o_if_rvalid = w_if_rsp;
  assign o_if_err    = w_if_rsp & w_head.err;
  assign o_if_rdata  = (w_if_rsp && !w_head.err) ? i_mem_rdata : '0;

  assign o_ls_rvalid = w_ls_rsp;
  assign o_ls_err    = w_ls_rsp & w_head.err;
  assign o_ls_rdata  = (w_ls_rsp && !w_head.err) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_umem_arbiter.sv
// Scoreboard bench for umem_arbiter: two instances (memory latency 1 and 3) share one stimulus
// stream; expected responses are queued at issue time and popped by an independent monitor.
module tb_umem_arbiter;

  localparam int WORDS = 2048;
  localparam int MAXS  = 4;

  typedef struct packed {
    logic [31:0] due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifFlush;
  logic        lsReq;
  logic        lsWe;
  logic [31:0] lsAddr;
  logic [31:0] lsWdata;

  logic        gnt [2][2];
  logic        rv [2][2];
  logic        er [2][2];
  logic [31:0] rd [2][2];
  logic        memWe [2];
  logic [31:0] memAddr [2];
  logic [31:0] memWdata [2];
  logic [31:0] memRdata [2];

  logic [31:0] envMem0 [WORDS];
  logic [31:0] envMem1 [WORDS];
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];

  logic [31:0] refMem [WORDS];
  exp_t        expQ [2][2][$];
  logic        expGnt [2];
  logic        expWe;
  logic        expAddrChk;
  logic [31:0] expAddr;
  logic [31:0] expWdata;
  int          mStreak;

  logic        sRst, sFlush, pIf, pLs, pLsWe;
  logic [31:0] pIfAddr, pLsAddr, pLsWdata;

  logic [31:0] cyc;
  bit          monOn;
  int          checks;
  int          errors;

  umem_arbiter #(.DATA_W(32), .MEM_WORDS(WORDS), .MEM_LATENCY(1), .MAX_LS_STREAK(MAXS)) u_lat1 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(ifReq), .i_if_addr(ifAddr), .i_if_flush(ifFlush),
    .o_if_gnt(gnt[0][0]), .o_if_rvalid(rv[0][0]), .o_if_rdata(rd[0][0]), .o_if_err(er[0][0]),
    .i_ls_req(lsReq), .i_ls_we(lsWe), .i_ls_addr(lsAddr), .i_ls_wdata(lsWdata),
    .o_ls_gnt(gnt[0][1]), .o_ls_rvalid(rv[0][1]), .o_ls_rdata(rd[0][1]), .o_ls_err(er[0][1]),
    .o_mem_we(memWe[0]), .o_mem_addr(memAddr[0]), .o_mem_wdata(memWdata[0]),
    .i_mem_rdata(memRdata[0])
  );

  umem_arbiter #(.DATA_W(32), .MEM_WORDS(WORDS), .MEM_LATENCY(3), .MAX_LS_STREAK(MAXS)) u_lat3 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(ifReq), .i_if_addr(ifAddr), .i_if_flush(ifFlush),
    .o_if_gnt(gnt[1][0]), .o_if_rvalid(rv[1][0]), .o_if_rdata(rd[1][0]), .o_if_err(er[1][0]),
    .i_ls_req(lsReq), .i_ls_we(lsWe), .i_ls_addr(lsAddr), .i_ls_wdata(lsWdata),
    .o_ls_gnt(gnt[1][1]), .o_ls_rvalid(rv[1][1]), .o_ls_rdata(rd[1][1]), .o_ls_err(er[1][1]),
    .o_mem_we(memWe[1]), .o_mem_addr(memAddr[1]), .o_mem_wdata(memWdata[1]),
    .i_mem_rdata(memRdata[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data_mem per instance: registered read with the instance's latency.
  always @(posedge clk) begin
    if (memWe[0]) envMem0[memAddr[0][12:2]] <= memWdata[0];
    pipe0 <= envMem0[memAddr[0][12:2]];
    if (memWe[1]) envMem1[memAddr[1][12:2]] <= memWdata[1];
    pipe1[0] <= envMem1[memAddr[1][12:2]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign memRdata[0] = pipe0;
  assign memRdata[1] = pipe1[2];

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] initWord(input int i);
    if (i == 4) return 32'h00A0_0093;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic isLegal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(4 * WORDS));
  endfunction

  function automatic logic [31:0] randAddr();
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel == 0) return 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
    if (sel == 1) return ($urandom_range(0, 1) == 0) ? 32'(32'h2000 + 4 * $urandom_range(0, 7)) : 32'hFFFF_FFFC;
    if (sel == 2) return 32'h0000_1FFC;
    return 32'(4 * $urandom_range(0, 31));
  endfunction

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pushResp(input int owner, input logic legal, input logic [31:0] data);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.due  = cyc + 32'(latOf(k));
      e.err  = ~legal;
      e.data = legal ? data : 32'h0;
      expQ[k][owner].push_back(e);
    end
  endtask

  // Drive one cycle of stimulus and predict grants, memory writes and responses from the rules.
  task automatic applyStimulus();
    logic ifWin, lsWin, legal;
    @(posedge clk);
    #1;
    rst = sRst; ifReq = pIf; ifAddr = pIfAddr; ifFlush = sFlush;
    lsReq = pLs; lsWe = pLsWe; lsAddr = pLsAddr; lsWdata = pLsWdata;
    expGnt[0] = 1'b0; expGnt[1] = 1'b0; expWe = 1'b0;
    expAddrChk = 1'b1; expAddr = 32'h0; expWdata = 32'h0;
    if (sRst) begin
      for (int k = 0; k < 2; k++)
        for (int o = 0; o < 2; o++) expQ[k][o].delete();
      mStreak = 0;
    end else begin
      if (sFlush) begin
        expQ[0][0].delete();
        expQ[1][0].delete();
      end
      ifWin = pIf && !sFlush && (!pLs || mStreak == MAXS);
      lsWin = pLs && !ifWin;
      if (ifWin) begin
        legal = isLegal(pIfAddr);
        expGnt[0] = 1'b1;
        expAddrChk = legal;
        expAddr = pIfAddr;
        pushResp(0, legal, refMem[pIfAddr[12:2]]);
        pIf = 1'b0;
      end else if (lsWin) begin
        legal = isLegal(pLsAddr);
        expGnt[1] = 1'b1;
        expAddrChk = legal;
        expAddr = pLsAddr;
        if (pLsWe && legal) begin
          refMem[pLsAddr[12:2]] = pLsWdata;
          expWe = 1'b1;
          expWdata = pLsWdata;
        end else begin
          pushResp(1, legal, pLsWe ? 32'h0 : refMem[pLsAddr[12:2]]);
        end
        pLs = 1'b0;
      end
      if (!ifReq || ifWin) mStreak = 0;
      else if (lsWin && mStreak < MAXS) mStreak++;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    string tag;
    for (int k = 0; k < 2; k++) begin
      tag = $sformatf("lat%0d", latOf(k));
      compareValue({tag, " if_gnt"}, 32'(gnt[k][0]), 32'(expGnt[0]));
      compareValue({tag, " ls_gnt"}, 32'(gnt[k][1]), 32'(expGnt[1]));
      compareValue({tag, " mem_we"}, 32'(memWe[k]), 32'(expWe));
      if (expAddrChk) compareValue({tag, " mem_addr"}, memAddr[k], expAddr);
      if (expWe) compareValue({tag, " mem_wdata"}, memWdata[k], expWdata);
      for (int o = 0; o < 2; o++) begin
        tag = $sformatf("lat%0d %s", latOf(k), (o == 0) ? "if" : "ls");
        if (expQ[k][o].size() > 0 && expQ[k][o][0].due <= cyc) begin
          e = expQ[k][o].pop_front();
          compareValue({tag, " rvalid"}, 32'(rv[k][o]), 32'h1);
          compareValue({tag, " err"}, 32'(er[k][o]), 32'(e.err));
          compareValue({tag, " rdata"}, rd[k][o], e.data);
        end else begin
          compareValue({tag, " rvalid idle"}, 32'(rv[k][o]), 32'h0);
          compareValue({tag, " rdata idle"}, rd[k][o], 32'h0);
        end
      end
    end
  endtask

  always @(negedge clk) if (monOn) checkOutput();

  task automatic idle(input int n);
    sRst = 1'b0; sFlush = 1'b0; pIf = 1'b0; pLs = 1'b0;
    repeat (n) applyStimulus();
  endtask

  task automatic runContention(input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      if (!pIf) begin pIf = 1'b1; pIfAddr = 32'(32'h100 + 4 * (i % 16)); end
      if (!pLs) begin pLs = 1'b1; pLsWe = 1'b0; pLsAddr = 32'(32'h200 + 4 * (i % 16)); end
      applyStimulus();
      if (chk) begin
        @(negedge clk);
        compareValue($sformatf("contention if_gnt #%0d", i), 32'(gnt[0][0]), 32'(i % 5 == 4));
        compareValue($sformatf("contention ls_gnt #%0d", i), 32'(gnt[0][1]), 32'(i % 5 != 4));
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; monOn = 0; mStreak = 0;
    rst = 1'b1; ifReq = 1'b0; ifAddr = 32'h0; ifFlush = 1'b0;
    lsReq = 1'b0; lsWe = 1'b0; lsAddr = 32'h0; lsWdata = 32'h0;
    expGnt[0] = 1'b0; expGnt[1] = 1'b0; expWe = 1'b0; expAddrChk = 1'b1;
    expAddr = 32'h0; expWdata = 32'h0;
    sRst = 1'b1; sFlush = 1'b0; pIf = 1'b0; pLs = 1'b0; pLsWe = 1'b0;
    pIfAddr = 32'h0; pLsAddr = 32'h0; pLsWdata = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      refMem[i]  = initWord(i);
      envMem0[i] <= initWord(i);
      envMem1[i] <= initWord(i);
    end

    applyStimulus();
    monOn = 1;
    repeat (2) applyStimulus();
    idle(2);

    $display("[TB] IF read of word 4");
    pIf = 1'b1; pIfAddr = 32'h10;
    applyStimulus();
    @(negedge clk);
    compareValue("if read gnt", 32'(gnt[0][0]), 32'h1);
    idle(1);
    @(negedge clk);
    compareValue("if read rvalid", 32'(rv[0][0]), 32'h1);
    compareValue("if read rdata", rd[0][0], 32'h00A0_0093);
    compareValue("if read err", 32'(er[0][0]), 32'h0);
    idle(3);

    $display("[TB] contention");
    runContention(10, 1'b1);
    idle(4);

    $display("[TB] store/load last word");
    pLs = 1'b1; pLsWe = 1'b1; pLsAddr = 32'h1FFC; pLsWdata = 32'hDEAD_BEEF;
    applyStimulus();
    @(negedge clk);
    compareValue("store mem_we", 32'(memWe[0]), 32'h1);
    compareValue("store mem_wdata", memWdata[0], 32'hDEAD_BEEF);
    pLs = 1'b1; pLsWe = 1'b0; pLsAddr = 32'h1FFC;
    applyStimulus();
    idle(1);
    @(negedge clk);
    compareValue("load back rvalid", 32'(rv[0][1]), 32'h1);
    compareValue("load back rdata", rd[0][1], 32'hDEAD_BEEF);
    idle(3);

    $display("[TB] illegal accesses");
    pLs = 1'b1; pLsWe = 1'b0; pLsAddr = 32'h6;
    applyStimulus();
    idle(1);
    @(negedge clk);
    compareValue("misaligned load err", 32'(er[0][1]), 32'h1);
    pLs = 1'b1; pLsWe = 1'b1; pLsAddr = 32'h2000; pLsWdata = 32'h1234_5678;
    applyStimulus();
    @(negedge clk);
    compareValue("oor store gnt", 32'(gnt[0][1]), 32'h1);
    compareValue("oor store mem_we", 32'(memWe[0]), 32'h0);
    idle(1);
    @(negedge clk);
    compareValue("oor store err", 32'(er[0][1]), 32'h1);
    pLs = 1'b1; pLsWe = 1'b0; pLsAddr = 32'h0;
    applyStimulus();
    pLs = 1'b1; pLsWe = 1'b0; pLsAddr = 32'h4;
    applyStimulus();
    idle(4);

    $display("[TB] flush");
    pIf = 1'b1; pIfAddr = 32'h10;
    applyStimulus();
    pIf = 1'b1; pIfAddr = 32'h14;
    applyStimulus();
    pIf = 1'b1; pIfAddr = 32'h18; sFlush = 1'b1;
    pLs = 1'b1; pLsWe = 1'b0; pLsAddr = 32'h40;
    applyStimulus();
    @(negedge clk);
    compareValue("flush blocks if_gnt", 32'(gnt[1][0]), 32'h0);
    compareValue("flush ls_gnt", 32'(gnt[1][1]), 32'h1);
    compareValue("flush same-cycle kill", 32'(rv[0][0]), 32'h0);
    idle(1);
    @(negedge clk);
    compareValue("flushed if t+3", 32'(rv[1][0]), 32'h0);
    idle(1);
    @(negedge clk);
    compareValue("flushed if t+4", 32'(rv[1][0]), 32'h0);
    idle(1);
    @(negedge clk);
    compareValue("ls after flush rvalid", 32'(rv[1][1]), 32'h1);
    compareValue("ls after flush rdata", rd[1][1], initWord(16));
    idle(3);

    $display("[TB] reset mid-operation");
    pIf = 1'b1; pIfAddr = 32'h10;
    applyStimulus();
    sRst = 1'b1; pIf = 1'b1; pIfAddr = 32'h20; pLs = 1'b1; pLsWe = 1'b0; pLsAddr = 32'h44;
    applyStimulus();
    @(negedge clk);
    compareValue("reset if_gnt", 32'(gnt[0][0]), 32'h0);
    compareValue("reset ls_gnt", 32'(gnt[0][1]), 32'h0);
    compareValue("reset mem_addr", memAddr[0], 32'h0);
    idle(5);
    runContention(3, 1'b0);
    sRst = 1'b1;
    applyStimulus();
    sRst = 1'b0;
    runContention(6, 1'b1);
    idle(4);

    $display("[TB] random traffic");
    for (int n = 0; n < 2000; n++) begin
      sRst   = ($urandom_range(0, 299) == 0);
      sFlush = ($urandom_range(0, 9) == 0);
      if (!pIf && $urandom_range(0, 2) != 0) begin
        pIf = 1'b1; pIfAddr = randAddr();
      end
      if (!pLs && $urandom_range(0, 2) != 0) begin
        pLs = 1'b1; pLsWe = 1'($urandom_range(0, 1)); pLsAddr = randAddr(); pLsWdata = $urandom();
      end
      applyStimulus();
    end
    idle(8);
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int o = 0; o < 2; o++)
        compareValue($sformatf("drained queue %0d/%0d", k, o), 32'(expQ[k][o].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
